// File: rtl/dmem_access_if.sv
// Bus bundle between the execute stage, the RV64 data-memory access controller and the data memory.
// The slave modport is the controller's view; master is the surrounding environment.
interface dmem_access_if #(
  parameter int DATA_BITS = 64,
  parameter int STRB_BITS = DATA_BITS / 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [2:0]           req_size;
  logic [DATA_BITS-1:0] req_addr;
  logic [DATA_BITS-1:0] req_wdata;
  logic                 ctr_clr;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [DATA_BITS-1:0] resp_rdata;
  logic [DATA_BITS-1:0] resp_addr;
  logic [2:0]           resp_size;
  logic                 resp_write;
  logic [DATA_BITS-1:0] resp_counter;
  logic                 resp_err;
  logic                 mem_req;
  logic                 mem_we;
  logic [DATA_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [STRB_BITS-1:0] mem_wstrb;
  logic                 mem_ack;
  logic [DATA_BITS-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata, ctr_clr,
           resp_ready, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_addr, resp_size, resp_write,
           resp_counter, resp_err, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, ctr_clr,
           resp_ready, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_addr, resp_size, resp_write,
           resp_counter, resp_err, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// RV64 load/store access controller: one outstanding request, lane replication, byte strobes, swap counter.
// Define DMEM_TIMEOUT_EN to add a MEM-state watchdog that turns a missing mem_ack into an error response.
module dmem_access_ctrl #(
  parameter int DATA_BITS      = 64,
  parameter int STRB_BITS      = DATA_BITS / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_access_if.slave   bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM      = 2'd1;
  localparam logic [1:0] RESP     = 2'd2;
  localparam logic [1:0] ERR_RESP = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [DATA_BITS-1:0] addr_q, addr_d;
  logic [2:0]           size_q, size_d;
  logic                 write_q, write_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [STRB_BITS-1:0] wstrb_q, wstrb_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [DATA_BITS-1:0] snap_q, snap_d;
  logic [DATA_BITS-1:0] ctr_q, ctr_d;

`ifdef DMEM_TIMEOUT_EN
  localparam int TIMER_BITS = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TIMER_BITS-1:0] timer_q, timer_d;
`endif

  logic                 illegal;
  logic [DATA_BITS-1:0] repl_wdata;
  logic [STRB_BITS-1:0] strb_base;

  // Alignment check: halfwords need addr[0]==0, words addr[1:0]==0, dwords and swap loads addr[2:0]==0.
  always_comb begin
    illegal = 1'b0;
    unique case (bus.req_size)
      3'b001, 3'b101: illegal = bus.req_addr[0];
      3'b010, 3'b110: illegal = |bus.req_addr[1:0];
      3'b011, 3'b111: illegal = |bus.req_addr[2:0];
      default:        illegal = 1'b0;
    endcase
    if (bus.req_write && bus.req_size[2]) illegal = 1'b1;
  end

  always_comb begin
    unique case (bus.req_size[1:0])
      2'b00: begin repl_wdata = {8{bus.req_wdata[7:0]}};  strb_base = 8'h01; end
      2'b01: begin repl_wdata = {4{bus.req_wdata[15:0]}}; strb_base = 8'h03; end
      2'b10: begin repl_wdata = {2{bus.req_wdata[31:0]}}; strb_base = 8'h0F; end
      default: begin repl_wdata = bus.req_wdata;          strb_base = 8'hFF; end
    endcase
  end

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    snap_d  = snap_q;
`ifdef DMEM_TIMEOUT_EN
    timer_d = timer_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          size_d  = bus.req_size;
          write_d = bus.req_write;
          wdata_d = repl_wdata;
          wstrb_d = bus.req_write ? (strb_base << bus.req_addr[2:0]) : '0;
          rdata_d = '0;
          err_d   = illegal;
          snap_d  = ctr_q;
          state_d = illegal ? ERR_RESP : MEM;
`ifdef DMEM_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end
      MEM: begin
`ifdef DMEM_TIMEOUT_EN
        timer_d = timer_q + 1'b1;
`endif
        if (bus.mem_ack) begin
          rdata_d = write_q ? '0 : bus.mem_rdata;
          state_d = RESP;
`ifdef DMEM_TIMEOUT_EN
        end else if (timer_q == TIMER_BITS'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = ERR_RESP;
`endif
        end
      end
      default: begin
        if (bus.resp_ready) state_d = IDLE;
      end
    endcase
  end

  // Clear dominates a simultaneous swap-load retirement.
  always_comb begin
    ctr_d = ctr_q;
    if (bus.ctr_clr)
      ctr_d = '0;
    else if (state_q == RESP && bus.resp_ready && size_q == 3'b111 && !write_q)
      ctr_d = ctr_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      snap_q  <= '0;
      ctr_q   <= '0;
`ifdef DMEM_TIMEOUT_EN
      timer_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      snap_q  <= snap_d;
      ctr_q   <= ctr_d;
`ifdef DMEM_TIMEOUT_EN
      timer_q <= timer_d;
`endif
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.resp_valid   = (state_q == RESP) || (state_q == ERR_RESP);
  assign bus.resp_rdata   = rdata_q;
  assign bus.resp_addr    = addr_q;
  assign bus.resp_size    = size_q;
  assign bus.resp_write   = write_q;
  assign bus.resp_counter = snap_q;
  assign bus.resp_err     = err_q;
  assign bus.mem_req      = (state_q == MEM);
  assign bus.mem_we       = (state_q == MEM) && write_q;
  assign bus.mem_addr     = {addr_q[DATA_BITS-1:3], 3'b000};
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_wstrb    = wstrb_q;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Load/store access controller of the RV64 data path; sits directly upstream of the load-data aligner.
- Accepts one memory request from the execute stage and drives the data-memory port: dword address, store lane replication and byte strobes, req/ack handshake.
- Returns the raw 64-bit read word plus the address, size and swap-counter context that the aligner needs to extract and extend the result.

Parameters:
- DATA_BITS, 64, data, address and counter width; fixed at 64.
- STRB_BITS, 8, byte strobes (DATA_BITS/8).
- TIMEOUT_CYCLES, 255, watchdog limit (only with DMEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1=store, 0=load.
- req_size  in  3  000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu, 111 swap-halfword load.
- req_addr  in  DATA_BITS  byte address.
- req_wdata  in  DATA_BITS  store data, right-justified.
- ctr_clr  in  1  clear swap counter.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  DATA_BITS  raw memory word (0 for stores and errors).
- resp_addr  out  DATA_BITS  original req_addr.
- resp_size  out  3  original req_size.
- resp_write  out  1  original req_write.
- resp_counter  out  DATA_BITS  swap counter value at request accept.
- resp_err  out  1  misaligned / illegal / timeout.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  DATA_BITS  {req_addr[63:3],3'b0}.
- mem_wdata  out  DATA_BITS  lane-replicated store data.
- mem_wstrb  out  STRB_BITS  byte enables (all 0 on loads).
- mem_ack  in  1  memory done; mem_rdata valid this cycle.
- mem_rdata  in  DATA_BITS  read word.

Behaviour:
- Reset: FSM=IDLE; all outputs and registers are 0, including resp_counter. req_ready is combinationally 1 in IDLE.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch addr/size/write/wdata/counter. Go to ERR_RESP if the request is illegal, else go to MEM.
  - MEM: mem_req=1, with mem_* held stable until mem_ack. On mem_ack, capture mem_rdata (loads) and go to RESP.
  - RESP / ERR_RESP: resp_valid=1, outputs held stable. On resp_ready, go to IDLE.
- Illegal requests:
  - h/hu with addr[0]!=0.
  - w/wu with addr[1:0]!=0.
  - d with addr[2:0]!=0.
  - size 111 with addr[2:0]!=0.
  - store with size 1xx.
  - Illegal requests never touch memory and return resp_err=1 with resp_rdata=0.
- Latency:
  - Accept at cycle 0; mem_req at cycle 1.
  - mem_ack at cycle k gives resp_valid at k+1.
  - Error responses assert resp_valid at cycle 1.
  - Minimum legal round trip is 3 cycles per transaction; one outstanding transaction.
- Stores:
  - Byte: mem_wdata = 8 copies of wdata[7:0]; wstrb = 1<<addr[2:0].
  - Half: 4 copies of wdata[15:0]; wstrb = 8'b11<<addr[2:0].
  - Word: 2 copies of wdata[31:0]; wstrb = 8'h0F<<addr[2:0].
  - Dword: wdata unchanged; wstrb = 8'hFF.
- Swap counter:
  - Increments by 1 (wraps modulo 2^64) on the resp handshake of a non-error size-111 load.
  - ctr_clr clears it at any time; clear wins over a simultaneous increment.
  - resp_counter reports the value sampled at accept.
- mem_ack outside MEM is ignored.
- rst_n low mid-transaction aborts immediately to IDLE with mem_req=0. The memory must tolerate a dropped request.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- Defined: an 8+ bit watchdog counts cycles in MEM. On reaching TIMEOUT_CYCLES without mem_ack, deassert mem_req and go to ERR_RESP with resp_err=1 and resp_rdata=0. The counter clears on entering MEM.
- Undefined: no watchdog; MEM waits indefinitely.

Test Plan:
- Load d @0x1000: mem_ack with rdata=0x0123456789ABCDEF, 2 cycles after mem_req -> resp_rdata=0x0123456789ABCDEF, resp_err=0, mem_wstrb=0, mem_addr=0x1000.
- Store b @0x1005, wdata=0xAA -> mem_wdata=0xAAAAAAAAAAAAAAAA, mem_wstrb=8'h20, mem_we=1. Store w @0x2004 -> wstrb=8'hF0.
- Load h @0x1003 -> no mem_req; resp_valid at cycle 1 with resp_err=1, resp_rdata=0. Store with size 111 -> same error response.
- Three size-111 loads @0x3000, then ctr_clr -> resp_counter 0,1,2; after clear, the next load reports 0. ctr_clr coincident with an increment -> counter is 0.
- Hold resp_ready=0 for 4 cycles -> resp_valid and all resp_* stay stable and req_ready=0. Drive rst_n low during MEM -> mem_req=0 and resp_valid=0 immediately.
- With DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no mem_ack -> mem_req drops after 4 cycles; resp_err=1. Without the macro -> mem_req stays 1.
